// File: rtl/alu_exec_stage.sv
// Single-entry execute stage around a combinational ALU.
// Evaluates an ARM-style condition against the NZCV register and retires the result one cycle later.

module alu #(
    parameter int unsigned N = 32
) (
    input  logic [3:0]   opcode,
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    output logic [N-1:0] result,
    output logic         n_flag,
    output logic         z_flag,
    output logic         c_flag,
    output logic         o_flag
);
    localparam int unsigned SW = $clog2(N);

    logic [N:0]    sum;
    logic [SW-1:0] shamt;

    assign shamt = b[SW-1:0];

    // C is carry-out (no-borrow on sub); C and V are cleared for non-arithmetic ops
    always_comb begin
        sum    = '0;
        result = '0;
        c_flag = 1'b0;
        o_flag = 1'b0;
        case (opcode)
            4'h0: begin
                sum    = {1'b0, a} + {1'b0, b};
                result = sum[N-1:0];
                c_flag = sum[N];
                o_flag = (a[N-1] == b[N-1]) && (result[N-1] != a[N-1]);
            end
            4'h1: begin
                sum    = {1'b0, a} + {1'b0, ~b} + (N+1)'(1);
                result = sum[N-1:0];
                c_flag = sum[N];
                o_flag = (a[N-1] != b[N-1]) && (result[N-1] != a[N-1]);
            end
            4'h2:    result = a & b;
            4'h3:    result = a | b;
            4'h4:    result = a ^ b;
            4'h5:    result = a << shamt;
            4'h6:    result = a >> shamt;
            4'h7:    result = N'($signed(a) >>> shamt);
            4'h8:    result = b;
            default: result = '0;
        endcase
    end

    assign n_flag = result[N-1];
    assign z_flag = (result == '0);
endmodule

module alu_exec_stage #(
    parameter int unsigned N = 32
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [3:0]   in_opcode,
    input  logic [N-1:0] in_a,
    input  logic [N-1:0] in_b,
    input  logic [3:0]   in_rd,
    input  logic [3:0]   in_cond,
    input  logic         in_set_flags,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [N-1:0] out_result,
    output logic [3:0]   out_rd,
    output logic         out_we,
    output logic [3:0]   flags
);
    logic [N-1:0] alu_result;
    logic         alu_n;
    logic         alu_z;
    logic         alu_c;
    logic         alu_v;
    logic         accept;
    logic         cond_pass;
    logic         f_n;
    logic         f_z;
    logic         f_c;
    logic         f_v;

    alu #(.N(N)) u_alu (
        .opcode (in_opcode),
        .a      (in_a),
        .b      (in_b),
        .result (alu_result),
        .n_flag (alu_n),
        .z_flag (alu_z),
        .c_flag (alu_c),
        .o_flag (alu_v)
    );

    assign in_ready = !out_valid || out_ready;
    assign accept   = in_valid && in_ready;
    assign {f_n, f_z, f_c, f_v} = flags;

    // Condition is judged against the architectural flags, never the incoming result
    always_comb begin
        cond_pass = 1'b0;
        case (in_cond)
            4'h0: cond_pass = f_z;
            4'h1: cond_pass = !f_z;
            4'h2: cond_pass = f_c;
            4'h3: cond_pass = !f_c;
            4'h4: cond_pass = f_n;
            4'h5: cond_pass = !f_n;
            4'h6: cond_pass = f_v;
            4'h7: cond_pass = !f_v;
            4'h8: cond_pass = f_c && !f_z;
            4'h9: cond_pass = !f_c || f_z;
            4'hA: cond_pass = (f_n == f_v);
            4'hB: cond_pass = (f_n != f_v);
            4'hC: cond_pass = !f_z && (f_n == f_v);
            4'hD: cond_pass = f_z || (f_n != f_v);
            4'hE: cond_pass = 1'b1;
            default: cond_pass = 1'b0;
        endcase
    end

    // Output register and flags; a failed condition still retires with out_we low
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid  <= 1'b0;
            out_result <= '0;
            out_rd     <= '0;
            out_we     <= 1'b0;
            flags      <= '0;
        end else if (accept) begin
            out_valid  <= 1'b1;
            out_result <= alu_result;
            out_rd     <= in_rd;
            out_we     <= cond_pass;
            if (in_set_flags && cond_pass) begin
                flags <= {alu_n, alu_z, alu_c, alu_v};
            end
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end
endmodule

// File: tb/tb_alu_exec_stage.sv
// Bench for alu_exec_stage: directed vector table, corner-case sequences and a random stream,
// all checked through an in-order scoreboard fed by a reference model.

module tb_alu_exec_stage;
    localparam int unsigned N = 32;

    typedef struct {
        logic [3:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [3:0]  rd;
        logic [3:0]  cond;
        logic        sf;
        logic [31:0] res;
        logic        we;
        logic [3:0]  fl;
    } vec_t;

    typedef struct {
        logic [31:0] res;
        logic [3:0]  rd;
        logic        we;
        logic [3:0]  fl;
    } exp_t;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          in_valid;
    logic          in_ready;
    logic [3:0]    in_opcode;
    logic [N-1:0]  in_a;
    logic [N-1:0]  in_b;
    logic [3:0]    in_rd;
    logic [3:0]    in_cond;
    logic          in_set_flags;
    logic          out_valid;
    logic          out_ready;
    logic [N-1:0]  out_result;
    logic [3:0]    out_rd;
    logic          out_we;
    logic [3:0]    flags;

    int   n_tests = 0;
    int   n_fail  = 0;
    int   stall_left = 0;
    bit   rand_ready = 0;
    logic [3:0] mflags = 4'h0;
    exp_t sb[$];
    vec_t tbl[16];

    alu_exec_stage #(.N(N)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_opcode    (in_opcode),
        .in_a         (in_a),
        .in_b         (in_b),
        .in_rd        (in_rd),
        .in_cond      (in_cond),
        .in_set_flags (in_set_flags),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_result   (out_result),
        .out_rd       (out_rd),
        .out_we       (out_we),
        .flags        (flags)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, got timeout required completion");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        n_tests++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %h required %h", name, act, req);
        end
    endtask

    function automatic logic cond_ok(input logic [3:0] c, input logic [3:0] f);
        logic n, z, cy, v;
        {n, z, cy, v} = f;
        case (c)
            4'd0:  return z;
            4'd1:  return !z;
            4'd2:  return cy;
            4'd3:  return !cy;
            4'd4:  return n;
            4'd5:  return !n;
            4'd6:  return v;
            4'd7:  return !v;
            4'd8:  return cy & !z;
            4'd9:  return !cy | z;
            4'd10: return n == v;
            4'd11: return n != v;
            4'd12: return !z & (n == v);
            4'd13: return z | (n != v);
            4'd14: return 1'b1;
            default: return 1'b0;
        endcase
    endfunction

    // Reference ALU: carry from unsigned compare/widening, overflow from 64-bit signed range
    function automatic exp_t model(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                                   input logic [3:0] rd, input logic [3:0] cond, input logic sf,
                                   input logic [3:0] fl_in);
        exp_t e;
        logic [32:0] wide;
        logic [31:0] r;
        logic c, v, pass;
        longint ss;
        c = 1'b0;
        v = 1'b0;
        case (op)
            4'd0: begin
                wide = {1'b0, a} + {1'b0, b};
                r    = wide[31:0];
                c    = wide[32];
                ss   = longint'($signed(a)) + longint'($signed(b));
                v    = (ss > 64'sd2147483647) || (ss < -(64'sd2147483648));
            end
            4'd1: begin
                r  = a - b;
                c  = (a >= b);
                ss = longint'($signed(a)) - longint'($signed(b));
                v  = (ss > 64'sd2147483647) || (ss < -(64'sd2147483648));
            end
            4'd2: r = a & b;
            4'd3: r = a | b;
            4'd4: r = a ^ b;
            4'd5: r = a << b[4:0];
            4'd6: r = a >> b[4:0];
            4'd7: r = 32'($signed(a) >>> b[4:0]);
            4'd8: r = b;
            default: r = 32'd0;
        endcase
        pass  = cond_ok(cond, fl_in);
        e.res = r;
        e.rd  = rd;
        e.we  = pass;
        e.fl  = (sf && pass) ? {r[31], (r == 32'd0), c, v} : fl_in;
        return e;
    endfunction

    task automatic drive_ready();
        if (stall_left > 0) begin
            out_ready = 1'b0;
            stall_left--;
        end else begin
            out_ready = rand_ready ? ($urandom_range(0, 3) != 0) : 1'b1;
        end
    endtask

    // Called #1 after a negedge, before the next active edge
    task automatic sample();
        exp_t e;
        if (out_valid && !out_ready) begin
            chk("stall_in_ready", 32'(in_ready), 32'd0);
            if (sb.size() > 0) chk("stall_result", out_result, sb[0].res);
        end
        if (out_valid && out_ready) begin
            if (sb.size() == 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL unexpected_output: got result %h with empty scoreboard, required none", out_result);
            end else begin
                e = sb.pop_front();
                chk("result", out_result, e.res);
                chk("rd", 32'(out_rd), 32'(e.rd));
                chk("we", 32'(out_we), 32'(e.we));
                chk("flags", 32'(flags), 32'(e.fl));
            end
        end
    endtask

    task automatic send(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                        input logic [3:0] rd, input logic [3:0] cond, input logic sf,
                        input bit use_tbl, input exp_t texp);
        exp_t m;
        bit   acc;
        int   g;
        acc = 1'b0;
        g   = 0;
        while (!acc && g < 64) begin
            @(negedge clk);
            in_valid     = 1'b1;
            in_opcode    = op;
            in_a         = a;
            in_b         = b;
            in_rd        = rd;
            in_cond      = cond;
            in_set_flags = sf;
            drive_ready();
            #1;
            sample();
            acc = in_ready;
            g++;
        end
        if (!acc) begin
            n_tests++;
            n_fail++;
            $display("FAIL accept_timeout: got in_ready 0 for %0d cycles, required 1", g);
        end else begin
            m      = model(op, a, b, rd, cond, sf, mflags);
            mflags = m.fl;
            sb.push_back(use_tbl ? texp : m);
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            in_valid = 1'b0;
            drive_ready();
            #1;
            sample();
        end
    endtask

    task automatic drain();
        int g;
        g = 0;
        while (sb.size() > 0 && g < 200) begin
            idle(1);
            g++;
        end
        chk("drain_empty", 32'(sb.size()), 32'd0);
    endtask

    initial begin
        exp_t none;
        exp_t te;
        none = '{32'd0, 4'd0, 1'b0, 4'd0};

        tbl[0]  = '{4'h0, 32'hFFFFFFFF, 32'h1,        4'd1,  4'hE, 1'b1, 32'h0,        1'b1, 4'b0110};
        tbl[1]  = '{4'h1, 32'd32,       32'd32,       4'd2,  4'hE, 1'b1, 32'h0,        1'b1, 4'b0110};
        tbl[2]  = '{4'h0, 32'd5,        32'd5,        4'd3,  4'h1, 1'b0, 32'd10,       1'b0, 4'b0110};
        tbl[3]  = '{4'h0, 32'd5,        32'd5,        4'd4,  4'h0, 1'b0, 32'd10,       1'b1, 4'b0110};
        tbl[4]  = '{4'h1, 32'd32,       32'd64,       4'd5,  4'hE, 1'b1, 32'hFFFFFFE0, 1'b1, 4'b1000};
        tbl[5]  = '{4'h0, 32'd1,        32'd2,        4'd6,  4'hB, 1'b0, 32'd3,        1'b1, 4'b1000};
        tbl[6]  = '{4'h0, 32'd1,        32'd1,        4'd7,  4'hA, 1'b1, 32'd2,        1'b0, 4'b1000};
        tbl[7]  = '{4'h0, 32'd1,        32'd1,        4'd8,  4'h0, 1'b1, 32'd2,        1'b0, 4'b1000};
        tbl[8]  = '{4'h0, 32'd0,        32'd0,        4'd9,  4'hF, 1'b1, 32'd0,        1'b0, 4'b1000};
        tbl[9]  = '{4'h0, 32'h7FFFFFFF, 32'd1,        4'd10, 4'hE, 1'b1, 32'h80000000, 1'b1, 4'b1001};
        tbl[10] = '{4'h0, 32'd2,        32'd2,        4'd11, 4'hA, 1'b0, 32'd4,        1'b1, 4'b1001};
        tbl[11] = '{4'h2, 32'hF0F0,     32'hFF0F,     4'd12, 4'hE, 1'b1, 32'hF000,     1'b1, 4'b0000};
        tbl[12] = '{4'h0, 32'd1,        32'd1,        4'd13, 4'h8, 1'b0, 32'd2,        1'b0, 4'b0000};
        tbl[13] = '{4'h0, 32'hFFFFFFFF, 32'hFFFFFFFF, 4'd14, 4'hE, 1'b1, 32'hFFFFFFFE, 1'b1, 4'b1010};
        tbl[14] = '{4'h0, 32'd3,        32'd3,        4'd15, 4'h8, 1'b0, 32'd6,        1'b1, 4'b1010};
        tbl[15] = '{4'h5, 32'd1,        32'd4,        4'd0,  4'h3, 1'b1, 32'd16,       1'b0, 4'b1010};

        rst_n = 1'b0;
        in_valid = 1'b0;
        in_opcode = 4'h0;
        in_a = '0;
        in_b = '0;
        in_rd = 4'h0;
        in_cond = 4'h0;
        in_set_flags = 1'b0;
        out_ready = 1'b1;
        #1;
        chk("reset_out_valid", 32'(out_valid), 32'd0);
        chk("reset_in_ready", 32'(in_ready), 32'd1);
        chk("reset_flags", 32'(flags), 32'd0);
        chk("reset_result", out_result, 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        // Directed vectors, downstream always ready
        for (int i = 0; i < 16; i++) begin
            te = '{tbl[i].res, tbl[i].rd, tbl[i].we, tbl[i].fl};
            send(tbl[i].op, tbl[i].a, tbl[i].b, tbl[i].rd, tbl[i].cond, tbl[i].sf, 1'b1, te);
        end
        drain();

        // Backpressure: two stalled cycles after the first op of a four-op stream
        send(4'h0, 32'd100, 32'd1, 4'd1, 4'hE, 1'b1, 1'b0, none);
        stall_left = 2;
        send(4'h1, 32'd7,   32'd9, 4'd2, 4'hE, 1'b1, 1'b0, none);
        send(4'h0, 32'd11,  32'd0, 4'd3, 4'hB, 1'b0, 1'b0, none);
        send(4'h4, 32'hAA,  32'h55, 4'd4, 4'h4, 1'b1, 1'b0, none);
        drain();

        // Random stream with random backpressure
        rand_ready = 1'b1;
        for (int i = 0; i < 200; i++) begin
            logic [31:0] ra, rb;
            ra = ($urandom_range(0, 3) == 0) ? 32'hFFFFFFFF : 32'($urandom);
            rb = ($urandom_range(0, 3) == 0) ? ra : 32'($urandom);
            send(4'($urandom_range(0, 15)), ra, rb, 4'($urandom_range(0, 15)),
                 4'($urandom_range(0, 15)), 1'($urandom_range(0, 1)), 1'b0, none);
            if ($urandom_range(0, 3) == 0) idle(1);
        end
        rand_ready = 1'b0;
        drain();

        // Asynchronous reset while stalled with a valid result held
        send(4'h0, 32'hFFFFFFFF, 32'hFFFFFFFF, 4'd7, 4'hE, 1'b1, 1'b0, none);
        stall_left = 1000;
        idle(1);
        chk("pre_reset_valid", 32'(out_valid), 32'd1);
        #1 rst_n = 1'b0;
        #1;
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_out_we", 32'(out_we), 32'd0);
        chk("rst_out_result", out_result, 32'd0);
        chk("rst_out_rd", 32'(out_rd), 32'd0);
        chk("rst_flags", 32'(flags), 32'd0);
        chk("rst_in_ready", 32'(in_ready), 32'd1);
        #1 rst_n = 1'b1;
        sb.delete();
        mflags = 4'h0;
        stall_left = 0;
        send(4'h1, 32'd3, 32'd3, 4'd5, 4'h0, 1'b1, 1'b0, none);
        send(4'h0, 32'd5, 32'd5, 4'd6, 4'h0, 1'b0, 1'b0, none);
        drain();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
